vram_line_writer: RTL and testbench

// Write side of the monochrome 640x480 line VRAM scanned by the VGA display block.

---
 rtl/vram_line_writer.sv | 150 +++++++++++++++
 tb/tb_vram_line_writer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vram_line_writer.sv
// Write side of the 640x480 monochrome line VRAM.
// Single-pixel set/clear requests arrive over valid/ready and are applied as a
// read-modify-write of the addressed 640-bit row. The display reads whole rows
// through a registered port with one cycle of latency. A full-frame clear runs
// after reset and whenever clr_start is pulsed while idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_CLEAR  | blank one row per cycle, rows 0..realln-1, then idle
// S_IDLE   | ready for a pixel request or a clear pulse
// S_RMW_RD | capture the target row into the row buffer
// S_RMW_WR | write the row buffer back with the single bit replaced
module vram_line_writer #(
  parameter int unsigned realpx = 640,
  parameter int unsigned realln = 480
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [8:0]        wr_y,
  input  logic              wr_val,
  input  logic              clr_start,
  output logic              busy,
  output logic              err_oob,
  input  logic [8:0]        vram_read_addr,
  output logic [0:realpx-1] line
);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_RMW_RD = 2'd2,
    S_RMW_WR = 2'd3
  } state_t;

  // Element x of a row is pixel x, so line[0] is the leftmost pixel.
  logic [0:realpx-1] r_mem [0:realln-1];

  state_t            r_state;
  logic [8:0]        r_row;
  logic [9:0]        r_x;
  logic [8:0]        r_y;
  logic              r_val;
  logic [0:realpx-1] r_buf;
  logic              r_err;

  logic              w_we;
  logic [8:0]        w_waddr;
  logic [0:realpx-1] w_wdata;
  logic [0:realpx-1] w_merged;
  logic              w_oob;
  logic              w_rd_ok;

  assign w_oob    = (wr_x >= 10'(realpx)) || (wr_y >= 9'(realln));
  assign w_rd_ok  = (vram_read_addr < 9'(realln));

  // Ready is combinational on clr_start so a simultaneous clear blocks acceptance.
  assign wr_ready = (r_state == S_IDLE) && !clr_start;
  assign busy     = (r_state != S_IDLE);
  assign err_oob  = r_err;

  // Row buffer with the latched pixel substituted.
  always_comb begin
    w_merged        = r_buf;
    w_merged[r_x]   = r_val;
  end

  // Single memory write port shared by the clear pass and the RMW write-back.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_y;
    w_wdata = w_merged;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_row;
      w_wdata = '0;
    end else if (r_state == S_RMW_WR) begin
      w_we    = 1'b1;
    end
  end

  // Sequencer: clear pass, request acceptance and the two-cycle RMW.
  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      r_state <= S_CLEAR;
      r_row   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_val   <= 1'b0;
      r_buf   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_row == 9'(realln - 1)) begin
            r_row   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_row   <= r_row + 9'd1;
          end
        end
        S_IDLE: begin
          if (clr_start) begin
            r_row   <= '0;
            r_err   <= 1'b0;
            r_state <= S_CLEAR;
          end else if (wr_valid) begin
            r_x   <= wr_x;
            r_y   <= wr_y;
            r_val <= wr_val;
            if (w_oob) begin
              r_err <= 1'b1;
            end else begin
              r_state <= S_RMW_RD;
            end
          end
        end
        S_RMW_RD: begin
          r_buf   <= r_mem[r_y];
          r_state <= S_RMW_WR;
        end
        S_RMW_WR: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Storage array; deliberately unreset, the clear pass blanks it.
  always_ff @(posedge dclk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Display read port; a same-edge write is seen on the following cycle.
  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      line <= '0;
    end else if (w_rd_ok) begin
      line <= r_mem[vram_read_addr];
    end else begin
      line <= '0;
    end
  end

endmodule

// File: tb/tb_vram_line_writer.sv
// Directed bench for vram_line_writer: clear timing, pixel writes, bounds,
// clear/request priority, display read latency and reset during RMW.
module tb_vram_line_writer;

  logic         dclk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [9:0]   wr_x = '0;
  logic [8:0]   wr_y = '0;
  logic         wr_val = 1'b0;
  logic         clr_start = 1'b0;
  logic         busy;
  logic         err_oob;
  logic [8:0]   vram_read_addr = '0;
  logic [0:639] line;

  int n_chk = 0;
  int n_pass = 0;

  vram_line_writer dut (
    .dclk           (dclk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_x           (wr_x),
    .wr_y           (wr_y),
    .wr_val         (wr_val),
    .clr_start      (clr_start),
    .busy           (busy),
    .err_oob        (err_oob),
    .vram_read_addr (vram_read_addr),
    .line           (line)
  );

  always #20 dclk = ~dclk;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Counts rising edges until wr_ready is seen high, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 2000) begin
      @(posedge dclk); #1;
      n++;
    end
  endtask

  // Handshake one request; low = cycles wr_ready stays low after acceptance.
  task automatic do_write(input int x, input int y, input bit v, output int low);
    int n;
    @(negedge dclk);
    wr_x = 10'(x); wr_y = 9'(y); wr_val = v; wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 2000) begin
      @(negedge dclk);
      n++;
    end
    chk("wr_accept_timeout", 640'(wr_ready), 640'(1));
    @(posedge dclk); #1;
    wr_valid = 1'b0;
    low = 0;
    while (!wr_ready && low < 10) begin
      @(posedge dclk); #1;
      low++;
    end
  endtask

  task automatic read_row(input int a, output logic [0:639] r);
    @(negedge dclk);
    vram_read_addr = 9'(a);
    @(posedge dclk); #1;
    r = line;
  endtask

  initial begin
    logic [0:639] r;
    logic [0:639] e;
    int n;
    int low;

    // reset values
    #5;
    chk("rst_busy", 640'(busy), 640'(1));
    chk("rst_ready", 640'(wr_ready), 640'(0));
    chk("rst_err", 640'(err_oob), 640'(0));
    chk("rst_line", line, 640'(0));

    // T1: clear pass after reset
    repeat (3) @(negedge dclk);
    rst = 1'b1;
    @(posedge dclk); #1;
    chk("t1_busy", 640'(busy), 640'(1));
    wait_ready(n);
    chk("t1_clear_cycles", 640'(n), 640'(479));
    chk("t1_busy_idle", 640'(busy), 640'(0));
    read_row(0, r);   chk("t1_row0", r, 640'(0));
    read_row(239, r); chk("t1_row239", r, 640'(0));
    read_row(479, r); chk("t1_row479", r, 640'(0));

    // T2: set and clear one pixel
    do_write(5, 10, 1'b1, low);
    chk("t2_low_cycles", 640'(low), 640'(2));
    e = '0; e[5] = 1'b1;
    read_row(10, r); chk("t2_row10_set", r, e);
    read_row(11, r); chk("t2_row11", r, 640'(0));
    do_write(5, 10, 1'b0, low);
    read_row(10, r); chk("t2_row10_clr", r, 640'(0));

    // T3: corners and out-of-range read address
    do_write(0, 0, 1'b1, low);
    do_write(639, 479, 1'b1, low);
    e = '0; e[0] = 1'b1;
    read_row(0, r);   chk("t3_row0", r, e);
    e = '0; e[639] = 1'b1;
    read_row(479, r); chk("t3_row479", r, e);
    read_row(480, r); chk("t3_addr480", r, 640'(0));

    // T4: out-of-range requests
    do_write(640, 3, 1'b1, low);
    chk("t4_x_oob_cycles", 640'(low), 640'(0));
    chk("t4_err_set", 640'(err_oob), 640'(1));
    do_write(3, 480, 1'b1, low);
    chk("t4_y_oob_cycles", 640'(low), 640'(0));
    read_row(3, r);   chk("t4_row3", r, 640'(0));
    e = '0; e[639] = 1'b1;
    read_row(479, r); chk("t4_row479", r, e);
    @(negedge dclk);
    clr_start = 1'b1;
    @(posedge dclk); #1;
    chk("t4_err_clr", 640'(err_oob), 640'(0));
    chk("t4_busy", 640'(busy), 640'(1));
    @(negedge dclk);
    clr_start = 1'b0;
    wait_ready(n);
    chk("t4_clear_cycles", 640'(n), 640'(480));
    read_row(479, r); chk("t4_row479_cleared", r, 640'(0));

    // T5: clear wins over a simultaneous request, which is then held
    @(negedge dclk);
    wr_x = 10'd7; wr_y = 9'd7; wr_val = 1'b1; wr_valid = 1'b1; clr_start = 1'b1;
    #1;
    chk("t5_ready_blocked", 640'(wr_ready), 640'(0));
    @(posedge dclk); #1;
    chk("t5_busy", 640'(busy), 640'(1));
    @(negedge dclk);
    clr_start = 1'b0;
    wait_ready(n);
    chk("t5_clear_cycles", 640'(n), 640'(480));
    @(posedge dclk); #1;
    wr_valid = 1'b0;
    chk("t5_accepted", 640'(wr_ready), 640'(0));
    wait_ready(n);
    chk("t5_rmw_cycles", 640'(n), 640'(2));
    e = '0; e[7] = 1'b1;
    read_row(7, r); chk("t5_row7", r, e);
    read_row(0, r); chk("t5_row0", r, 640'(0));

    // T6: read-before-write on the display port
    @(negedge dclk);
    vram_read_addr = 9'd20;
    wr_x = 10'd9; wr_y = 9'd20; wr_val = 1'b1; wr_valid = 1'b1;
    @(posedge dclk); #1;
    wr_valid = 1'b0;
    @(posedge dclk); #1;
    @(posedge dclk); #1;
    chk("t6_old_data", 640'(line[9]), 640'(0));
    @(posedge dclk); #1;
    chk("t6_new_data", 640'(line[9]), 640'(1));

    // T6: reset during RMW_RD restarts the clear pass
    @(negedge dclk);
    wr_x = 10'd11; wr_y = 9'd30; wr_val = 1'b1; wr_valid = 1'b1;
    @(posedge dclk); #1;
    wr_valid = 1'b0;
    chk("t6_in_rmw", 640'(busy), 640'(1));
    #5;
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", 640'(busy), 640'(1));
    chk("t6_rst_ready", 640'(wr_ready), 640'(0));
    chk("t6_rst_line", line, 640'(0));
    @(negedge dclk);
    rst = 1'b1;
    wait_ready(n);
    chk("t6_clear_cycles", 640'(n), 640'(480));
    read_row(30, r); chk("t6_row30", r, 640'(0));
    read_row(20, r); chk("t6_row20", r, 640'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
